// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, default sizes and address-split helpers for the data cache
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SETS       = 8;
    localparam int DEF_WORDS      = 4;
    localparam int BYTE_OFF_W     = 2;

    // Lowest tag bit: byte offset, then word offset, then index.
    function automatic int tag_lo(input int sets, input int words);
        return BYTE_OFF_W + $clog2(words) + $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag, valid and data arrays with async read and sync write
module cache_line_store
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS,
    parameter int IDX_W          = $clog2(SETS),
    parameter int OFF_W          = $clog2(WORDS_PER_LINE),
    parameter int TAG_W          = DATA_WIDTH - tag_lo(SETS, WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      index,
    input  logic [OFF_W-1:0]      rd_offset,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  word_we,
    input  logic [OFF_W-1:0]      wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  tag_we,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  wr_valid
);

    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS_PER_LINE];
    logic [SETS-1:0]       valid_q;

    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid_q[index];
    assign rd_data  = data_mem[{index, rd_offset}];

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[{index, wr_offset}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[index] <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[index] <= wr_valid;
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache for the memory stage
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memreadm,
    input  logic                  memwritem,
    input  logic [DATA_WIDTH-1:0] addrm,
    input  logic [DATA_WIDTH-1:0] writedatam,
    output logic [DATA_WIDTH-1:0] readdatam,
    output logic                  stallm,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int TAG_LO = tag_lo(SETS, WORDS_PER_LINE);
    localparam int TAG_W  = DATA_WIDTH - TAG_LO;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    cache_state_t     state;
    logic [OFF_W-1:0] cnt;

    logic [IDX_W-1:0]      index;
    logic [OFF_W-1:0]      offset;
    logic [TAG_W-1:0]      tag;
    logic [TAG_W-1:0]      line_tag;
    logic                  line_valid;
    logic [DATA_WIDTH-1:0] line_word;
    logic                  hit;
    logic                  last_beat;
    logic                  unused_byte_off;

    assign index           = addrm[TAG_LO-1 -: IDX_W];
    assign offset          = addrm[BYTE_OFF_W+OFF_W-1 -: OFF_W];
    assign tag             = addrm[DATA_WIDTH-1:TAG_LO];
    assign hit             = line_valid && (line_tag == tag);
    assign last_beat       = (cnt == LAST_BEAT);
    assign unused_byte_off = ^addrm[BYTE_OFF_W-1:0];

    logic                  word_we;
    logic [OFF_W-1:0]      wr_offset;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  tag_we;
    logic                  wr_valid;

    always_comb begin
        word_we   = 1'b0;
        wr_offset = offset;
        wr_data   = writedatam;
        tag_we    = 1'b0;
        wr_valid  = 1'b0;
        case (state)
            // Invalidate at miss detect so stale data never pairs with a half-refilled line.
            IDLE: tag_we = memreadm && !hit;
            FILL: begin
                word_we   = mem_ready;
                wr_offset = cnt;
                wr_data   = mem_rdata;
                tag_we    = mem_ready && last_beat;
                wr_valid  = 1'b1;
            end
            WRITE: word_we = mem_ready && hit;
            default: ;
        endcase
    end

    cache_line_store #(
        .DATA_WIDTH     (DATA_WIDTH),
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .OFF_W          (OFF_W),
        .TAG_W          (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .rd_offset (offset),
        .rd_tag    (line_tag),
        .rd_valid  (line_valid),
        .rd_data   (line_word),
        .word_we   (word_we),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .wr_tag    (tag),
        .wr_valid  (wr_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memreadm && !hit) begin
                        state <= FILL;
                        cnt   <= '0;
                    end else if (memwritem) begin
                        state <= WRITE;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are decoded from registered state and the pipeline-held addrm,
    // so they stay stable until mem_ready.
    always_comb begin
        readdatam = '0;
        stallm    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                stallm = memwritem || (memreadm && !hit);
                if (memreadm && hit) begin
                    readdatam = line_word;
                end
            end
            FILL: begin
                stallm   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addrm[DATA_WIDTH-1:BYTE_OFF_W+OFF_W], cnt, {BYTE_OFF_W{1'b0}}};
            end
            WRITE: begin
                stallm    = !mem_ready;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addrm[DATA_WIDTH-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
                mem_wdata = writedatam;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - randomized self-checking bench for data_cache against a line-level reference model
module tb_data_cache;

    logic        clk = 0;
    logic        rst = 1;
    logic        memreadm = 0;
    logic        memwritem = 0;
    logic [31:0] addrm = 0;
    logic [31:0] writedatam = 0;
    logic [31:0] readdatam;
    logic        stallm;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 0;
    logic [31:0] mem_rdata = 0;

    int total = 0;
    int bad = 0;

    data_cache dut (
        .clk        (clk),
        .rst        (rst),
        .memreadm   (memreadm),
        .memwritem  (memwritem),
        .addrm      (addrm),
        .writedatam (writedatam),
        .readdatam  (readdatam),
        .stallm     (stallm),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing memory with configurable wait states per request.
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];
    int          mem_wait = 0;
    int          wcnt = 0;
    int          unstable = 0;
    bit          pend = 0;
    logic [31:0] pend_addr, pend_wdata;
    logic        pend_we;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : pattern(a);
    endfunction

    always begin
        @(posedge clk);
        #2;
        if (rst || !mem_req) begin
            mem_ready = 0;
            wcnt = 0;
            pend = 0;
        end else begin
            if (pend && (mem_addr !== pend_addr || mem_we !== pend_we || (mem_we && mem_wdata !== pend_wdata)))
                unstable++;
            if (wcnt >= mem_wait) begin
                mem_ready = 1;
                wcnt = 0;
                pend = 0;
                if (mem_we) begin
                    bmem[mem_addr] = mem_wdata;
                    wr_log.push_back(mem_addr);
                end else begin
                    mem_rdata = bmem_rd(mem_addr);
                    rd_log.push_back(mem_addr);
                end
            end else begin
                mem_ready = 0;
                wcnt++;
                pend = 1;
                pend_addr = mem_addr;
                pend_we = mem_we;
                pend_wdata = mem_wdata;
            end
        end
    end

    // Reference model: per-set valid/tag plus architectural memory contents.
    bit          ref_valid [8];
    logic [24:0] ref_tag [8];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[a[6:4]] && ref_tag[a[6:4]] == a[31:7];
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
    endfunction

    function automatic int exp_stalls(input bit ld, input logic [31:0] a, input int w);
        if (!ld) return 1 + w;
        return ref_hit(a) ? 0 : 1 + 4 * (w + 1);
    endfunction

    function automatic void ref_apply(input bit ld, input logic [31:0] a, input logic [31:0] d);
        if (ld) begin
            ref_valid[a[6:4]] = 1;
            ref_tag[a[6:4]] = a[31:7];
        end else begin
            ref_mem[a] = d;
        end
    endfunction

    task automatic access(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
        @(posedge clk);
        #1;
        rd_log.delete();
        wr_log.delete();
        memreadm = ld;
        memwritem = !ld;
        addrm = a;
        writedatam = wd;
        stalls = 0;
        rd = 'x;
        forever begin
            @(negedge clk);
            if (!stallm) begin
                rd = readdatam;
                break;
            end
            stalls++;
            if (stalls > 300) break;
        end
        @(posedge clk);
        #1;
        memreadm = 0;
        memwritem = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (stallm !== 1'b0 || mem_req !== 1'b0 || readdatam !== 32'h0) begin
            bad++;
            $display("FAIL reset: stallm=%b mem_req=%b readdatam=%h required 0 0 0", stallm, mem_req, readdatam);
        end
        rst = 0;
        foreach (ref_valid[i]) ref_valid[i] = 0;
    endtask

    task automatic test_load_miss;
        logic [31:0] rd;
        int st;
        bmem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        mem_wait = 0;
        access(1, 32'h40, 0, rd, st);
        ref_apply(1, 32'h40, 0);
        total++;
        if (st !== 5) begin bad++; $display("FAIL miss_stall: got %0d required 5", st); end
        total++;
        if (rd_log.size() != 4 || rd_log[0] !== 32'h40 || rd_log[1] !== 32'h44 ||
            rd_log[2] !== 32'h48 || rd_log[3] !== 32'h4C) begin
            bad++;
            $display("FAIL miss_addrs: got %p required 40 44 48 4c", rd_log);
        end
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL miss_data: got %h required deadbeef", rd); end
    endtask

    task automatic test_load_hit;
        logic [31:0] rd;
        int st;
        access(1, 32'h44, 0, rd, st);
        total++;
        if (st !== 0 || rd_log.size() != 0) begin
            bad++;
            $display("FAIL hit_stall: stalls=%0d reads=%0d required 0 0", st, rd_log.size());
        end
        total++;
        if (rd !== pattern(32'h44)) begin bad++; $display("FAIL hit_data: got %h required %h", rd, pattern(32'h44)); end
    endtask

    task automatic test_store_hit_delay;
        logic [31:0] rd;
        int st;
        mem_wait = 2;
        unstable = 0;
        access(0, 32'h48, 32'h11223344, rd, st);
        ref_apply(0, 32'h48, 32'h11223344);
        total++;
        if (st !== 3 || wr_log.size() != 1 || wr_log[0] !== 32'h48) begin
            bad++;
            $display("FAIL store_hit: stalls=%0d writes=%0d required 3 1 at 48", st, wr_log.size());
        end
        total++;
        if (unstable !== 0) begin bad++; $display("FAIL req_stable: changes=%0d required 0", unstable); end
        mem_wait = 0;
        access(1, 32'h48, 0, rd, st);
        total++;
        if (st !== 0 || rd !== 32'h11223344) begin
            bad++;
            $display("FAIL store_hit_read: stalls=%0d data=%h required 0 11223344", st, rd);
        end
    endtask

    task automatic test_store_miss;
        logic [31:0] rd;
        int st;
        access(0, 32'h1000, 32'hCAFE0001, rd, st);
        ref_apply(0, 32'h1000, 32'hCAFE0001);
        total++;
        if (st !== 1 || wr_log.size() != 1 || wr_log[0] !== 32'h1000) begin
            bad++;
            $display("FAIL store_miss: stalls=%0d writes=%0d required 1 1", st, wr_log.size());
        end
        access(1, 32'h1000, 0, rd, st);
        ref_apply(1, 32'h1000, 0);
        total++;
        if (st !== 5 || rd_log.size() != 4 || rd !== 32'hCAFE0001) begin
            bad++;
            $display("FAIL no_allocate: stalls=%0d reads=%0d data=%h required 5 4 cafe0001", st, rd_log.size(), rd);
        end
    endtask

    task automatic test_evict;
        logic [31:0] rd;
        int st, ex;
        logic [31:0] seq [3];
        seq[0] = 32'h40; seq[1] = 32'hC0; seq[2] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            ex = exp_stalls(1, seq[i], 0);
            access(1, seq[i], 0, rd, st);
            total++;
            if (st !== ex || rd !== ref_rd(seq[i]) || (i > 0 && rd_log.size() != 4)) begin
                bad++;
                $display("FAIL evict_%0d: stalls=%0d data=%h required %0d %h", i, st, rd, ex, ref_rd(seq[i]));
            end
            ref_apply(1, seq[i], 0);
        end
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] rd;
        int st, n;
        @(posedge clk);
        #1;
        rd_log.delete();
        memreadm = 1;
        addrm = 32'h200;
        n = 0;
        while (rd_log.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        memreadm = 0;
        rst = 1;
        #1;
        total++;
        if (mem_req !== 1'b0 || readdatam !== 32'h0) begin
            bad++;
            $display("FAIL rst_fill: mem_req=%b readdatam=%h required 0 0", mem_req, readdatam);
        end
        @(posedge clk);
        #1;
        rst = 0;
        foreach (ref_valid[i]) ref_valid[i] = 0;
        access(1, 32'h200, 0, rd, st);
        ref_apply(1, 32'h200, 0);
        total++;
        if (st !== 5 || rd_log.size() != 4 || rd !== ref_rd(32'h200)) begin
            bad++;
            $display("FAIL refill_after_rst: stalls=%0d reads=%0d data=%h required 5 4 %h", st, rd_log.size(), rd, ref_rd(32'h200));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d;
        int st, ex, exr, exw;
        bit ld;
        unstable = 0;
        for (int i = 0; i < 60; i++) begin
            ld = ($urandom_range(0, 2) != 0);
            a = {23'h0, 2'($urandom_range(0, 3)), 3'($urandom), 2'($urandom), 2'b00};
            d = $urandom;
            mem_wait = $urandom_range(0, 2);
            ex = exp_stalls(ld, a, mem_wait);
            exr = (ld && !ref_hit(a)) ? 4 : 0;
            exw = ld ? 0 : 1;
            access(ld, a, d, rd, st);
            ref_apply(ld, a, d);
            total++;
            if (st !== ex || rd_log.size() != exr || wr_log.size() != exw || (ld && rd !== ref_rd(a))) begin
                bad++;
                $display("FAIL rand_%0d: ld=%0b a=%h stalls=%0d rd=%0d wr=%0d data=%h required %0d %0d %0d %h",
                         i, ld, a, st, rd_log.size(), wr_log.size(), rd, ex, exr, exw, ld ? ref_rd(a) : 32'h0);
            end
        end
        total++;
        if (unstable !== 0) begin bad++; $display("FAIL rand_stable: changes=%0d required 0", unstable); end
        mem_wait = 0;
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit_delay();
        test_store_miss();
        test_evict();
        test_reset_mid_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
